mpu_port_arbiter: RTL and testbench

- Multi-channel front-end for the MPU: accepts protection requests (malloc, free, checked read/write) from NUM_PORTS independent cores and serialises them onto one downstream MPU command interface.
- Round-robin arbitration; core_id is stamped from the port index, so cores cannot spoof it.
- Adds a per-transaction watchdog with a TIMEOUT response, and a saturating timeout statistic.
- Sits between the core interconnect and the MPU top.

---
 rtl/mpu_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mpu_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_port_arbiter.sv
// Round-robin front-end serialising per-core MPU requests onto one downstream
// command interface, with a per-transaction watchdog and timeout statistic.
package mpu_pkg;
  typedef enum logic [1:0] {
    MPU_NO_ERROR       = 2'd0,
    MPU_ACCESS_GRANTED = 2'd1,
    MPU_ACCESS_DENIED  = 2'd2,
    MPU_INVALID        = 2'd3
  } mpu_error_t;

  typedef enum logic [1:0] {
    RESP_OK      = 2'b00,
    RESP_DENIED  = 2'b01,
    RESP_TIMEOUT = 2'b10
  } resp_err_t;
endpackage

module mpu_port_arbiter
  import mpu_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int CORE_ID_WIDTH  = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req_valid,
  output logic [NUM_PORTS-1:0]             req_ready,
  input  logic [NUM_PORTS-1:0]             req_cfg,
  input  logic [NUM_PORTS-1:0]             req_we,
  input  logic [NUM_PORTS-1:0]             req_free_reserve,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]             resp_valid,
  output logic [DATA_WIDTH-1:0]            resp_rdata,
  output logic [1:0]                       resp_err,
  output logic                             m_cs,
  output logic                             m_cfg,
  output logic                             m_we,
  output logic                             m_free_reserve,
  output logic [CORE_ID_WIDTH-1:0]         m_core_id,
  output logic [ADDR_WIDTH-1:0]            m_addr,
  output logic [DATA_WIDTH-1:0]            m_wdata,
  input  logic                             m_rdy,
  input  logic                             m_bsy,
  input  logic [DATA_WIDTH-1:0]            m_rdata,
  input  mpu_error_t                       m_error,
  output logic [15:0]                      timeout_count
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                   state;
  logic [CORE_ID_WIDTH-1:0] rr_ptr;
  logic [CORE_ID_WIDTH-1:0] next_ptr;
  logic [CORE_ID_WIDTH-1:0] pick_base;
  logic [CORE_ID_WIDTH-1:0] scan_idx;
  logic [CORE_ID_WIDTH-1:0] pick_idx;
  logic                     pick_found;
  logic                     grant_en;
  logic [WD_W-1:0]          watchdog;

  // m_core_id doubles as the current winner; NUM_PORTS is a power of two so
  // the increment wraps on its own.
  // NOTE: every always_comb output gets a default before any branch, so no latch.
  always_comb begin
    next_ptr   = m_core_id + 1'b1;
    pick_base  = (state == RESP) ? next_ptr : rr_ptr;
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    // Scan from the farthest offset down so the closest requester wins.
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      scan_idx = pick_base + CORE_ID_WIDTH'(k);
      if (req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
    grant_en = pick_found && !m_bsy;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      watchdog       <= '0;
      req_ready      <= '0;
      resp_valid     <= '0;
      resp_rdata     <= '0;
      resp_err       <= RESP_OK;
      m_cs           <= 1'b0;
      m_cfg          <= 1'b0;
      m_we           <= 1'b0;
      m_free_reserve <= 1'b0;
      m_core_id      <= '0;
      m_addr         <= '0;
      m_wdata        <= '0;
      timeout_count  <= '0;
    end else begin
      req_ready  <= '0;
      resp_valid <= '0;
      m_cs       <= 1'b0;
      case (state)
        // RESP arbitrates too, so back-to-back transactions lose no cycle.
        IDLE, RESP: begin
          if (state == RESP) rr_ptr <= next_ptr;
          if (grant_en) begin
            m_core_id      <= pick_idx;
            m_cfg          <= req_cfg[pick_idx];
            m_we           <= req_we[pick_idx];
            m_free_reserve <= req_free_reserve[pick_idx];
            m_addr         <= req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            m_wdata        <= req_wdata[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
            req_ready      <= NUM_PORTS'(1) << pick_idx;
            state          <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          m_cs     <= 1'b1;
          watchdog <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // Completion takes priority over a watchdog expiring in the same cycle.
          if (m_rdy) begin
            resp_rdata <= m_rdata;
            case (m_error)
              MPU_NO_ERROR, MPU_ACCESS_GRANTED: resp_err <= RESP_OK;
              default:                          resp_err <= RESP_DENIED;
            endcase
            resp_valid <= NUM_PORTS'(1) << m_core_id;
            state      <= RESP;
          end else if (watchdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
            resp_rdata <= '0;
            resp_err   <= RESP_TIMEOUT;
            resp_valid <= NUM_PORTS'(1) << m_core_id;
            if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
            state      <= RESP;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_port_arbiter.sv
// Directed and randomized bench for mpu_port_arbiter against a transaction-level
// round-robin / watchdog reference model.
module tb_mpu_port_arbiter;
  import mpu_pkg::*;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 2;
  localparam int TO = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    req_valid, req_ready, req_cfg, req_we, req_free_reserve;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_wdata;
  logic [NP-1:0]    resp_valid;
  logic [DW-1:0]    resp_rdata;
  logic [1:0]       resp_err;
  logic             m_cs, m_cfg, m_we, m_free_reserve;
  logic [CW-1:0]    m_core_id;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_wdata;
  logic             m_rdy, m_bsy;
  logic [DW-1:0]    m_rdata;
  mpu_error_t       m_error;
  logic [15:0]      timeout_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int model_ptr;
  int tc_exp;

  logic        port_cfg[NP], port_we[NP], port_fr[NP];
  logic [31:0] port_addr[NP], port_wdata[NP];

  mpu_port_arbiter #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .CORE_ID_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cfg(req_cfg),
    .req_we(req_we), .req_free_reserve(req_free_reserve),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .m_cs(m_cs), .m_cfg(m_cfg), .m_we(m_we), .m_free_reserve(m_free_reserve),
    .m_core_id(m_core_id), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdy(m_rdy), .m_bsy(m_bsy), .m_rdata(m_rdata), .m_error(m_error),
    .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_port(input int i, input logic v, input logic c, input logic w,
                            input logic f, input logic [31:0] a, input logic [31:0] d);
    port_cfg[i] = c; port_we[i] = w; port_fr[i] = f; port_addr[i] = a; port_wdata[i] = d;
    req_valid[i] = v; req_cfg[i] = c; req_we[i] = w; req_free_reserve[i] = f;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // Winner = first requester at or after the pointer, wrapping around.
  function automatic int rr_pick(input int ptr, input logic [NP-1:0] mask);
    for (int k = 0; k < NP; k++)
      if (mask[(ptr + k) % NP]) return (ptr + k) % NP;
    return 0;
  endfunction

  function automatic logic [1:0] map_err(input mpu_error_t e);
    if (e == MPU_ACCESS_DENIED) return 2'b01;
    return 2'b00;
  endfunction

  task automatic wait_ready(output logic [NP-1:0] rv, output int t);
    rv = '0;
    t  = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        rv = req_ready;
        t  = cyc;
        break;
      end
    end
  endtask

  // Called at the negedge of the grant cycle; plays the MPU with completion
  // lat cycles after m_cs (lat=0: never) and checks the response.
  task automatic respond(input int w, input int lat, input logic [31:0] rd, input mpu_error_t e);
    logic        exp_to;
    int          rs;
    int          bad;
    logic [1:0]  exp_err;
    logic [31:0] exp_rd;
    @(negedge clk);
    check("m_cs_pulse", {req_ready, m_cs}, {4'b0000, 1'b1});
    check("m_core_id", m_core_id, w);
    check("m_fields", {m_cfg, m_we, m_free_reserve}, {port_cfg[w], port_we[w], port_fr[w]});
    check("m_addr", m_addr, port_addr[w]);
    check("m_wdata", m_wdata, port_wdata[w]);
    exp_to = (lat < 1) || (lat > TO - 1);
    rs     = exp_to ? TO : lat + 1;
    bad    = 0;
    for (int s = 1; s <= rs; s++) begin
      @(negedge clk);
      m_rdy = (s == lat);
      if (s == lat) begin
        m_rdata = rd;
        m_error = e;
      end
      if (s < rs && (resp_valid != '0 || m_cs)) bad++;
    end
    m_rdy = 1'b0;
    if (exp_to) begin
      exp_err = 2'b10;
      exp_rd  = '0;
      if (tc_exp < 16'hFFFF) tc_exp++;
    end else begin
      exp_err = map_err(e);
      exp_rd  = rd;
    end
    check("resp_early", bad, 0);
    check("resp_valid", resp_valid, NP'(1) << w);
    check("resp_rdata", resp_rdata, exp_rd);
    check("resp_err", resp_err, exp_err);
    check("timeout_count", timeout_count, tc_exp);
    model_ptr = (w + 1) % NP;
  endtask

  initial begin
    logic [NP-1:0] rv;
    logic [NP-1:0] mask;
    int            t, prev_t, bad, w, lat;
    mpu_error_t    e;

    rst = 1'b1; req_valid = '0; req_cfg = '0; req_we = '0; req_free_reserve = '0;
    req_addr = '0; req_wdata = '0;
    m_rdy = 1'b0; m_bsy = 1'b0; m_rdata = '0; m_error = MPU_NO_ERROR;
    model_ptr = 0; tc_exp = 0;
    for (int i = 0; i < NP; i++) drive_port(i, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    check("reset_ctrl", {req_ready, resp_valid, m_cs, m_cfg, m_we, m_free_reserve, m_core_id, resp_err}, 0);
    check("reset_data", {m_addr, m_wdata}, 0);
    check("reset_stats", {resp_rdata, timeout_count}, 0);
    rst = 1'b0;

    // Single port 2 check-read, completion 3 cycles after m_cs.
    drive_port(2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
    wait_ready(rv, t);
    check("single_grant", rv, 4'b0100);
    req_valid = '0;
    respond(2, 3, 32'hDEADBEEF, MPU_ACCESS_GRANTED);

    // Port 1 malloc denied, then pointer must sit at 2.
    drive_port(1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h2000, 32'h55);
    wait_ready(rv, t);
    check("denied_grant", rv, 4'b0010);
    req_valid = '0;
    respond(1, 2, 32'hCAFE0001, MPU_ACCESS_DENIED);
    check("ptr_after_denied", model_ptr, 2);
    drive_port(0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA0, 32'h1);
    drive_port(1, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA1, 32'h2);
    drive_port(2, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA2, 32'h3);
    wait_ready(rv, t);
    check("ptr_grant", rv, 4'b0100);
    req_valid = '0;
    respond(2, 1, 32'h0BAD_F00D, MPU_NO_ERROR);

    // Hung MPU: timeout, busy blocks new grants, late m_rdy ignored.
    drive_port(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0);
    wait_ready(rv, t);
    check("to_grant", rv, 4'b0001);
    req_valid = '0;
    m_bsy = 1'b1;
    drive_port(1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h400, 32'h77);
    respond(0, 0, 32'h0, MPU_NO_ERROR);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      m_rdy   = (i == 3);
      m_rdata = 32'hFFFF_0000;
      if (req_ready != '0 || m_cs || resp_valid != '0) bad++;
    end
    m_rdy = 1'b0;
    check("busy_blocks", bad, 0);
    check("late_rdy_hold", {resp_rdata, resp_err, timeout_count}, {32'h0, 2'b10, 16'd1});
    m_bsy = 1'b0;
    wait_ready(rv, t);
    check("after_busy_grant", rv, 4'b0010);
    req_valid = '0;
    respond(1, 1, 32'h1111_2222, MPU_ACCESS_GRANTED);

    // m_rdy coincides with the watchdog threshold: completion wins.
    drive_port(3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h500, 32'h0);
    wait_ready(rv, t);
    check("thresh_grant", rv, 4'b1000);
    req_valid = '0;
    respond(3, TO - 1, 32'h1234_5678, MPU_ACCESS_GRANTED);

    // Reset during WAIT abandons the transaction.
    drive_port(3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h600, 32'h0);
    wait_ready(rv, t);
    check("rst_txn_grant", rv, 4'b1000);
    req_valid = '0;
    @(negedge clk);
    check("rst_txn_cs", m_cs, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_ctrl", {req_ready, resp_valid, m_cs, m_cfg, m_we, m_free_reserve, m_core_id, resp_err}, 0);
    check("async_rst_data", {m_addr, m_wdata, resp_rdata, timeout_count}, 0);
    tc_exp = 0;
    model_ptr = 0;
    for (int i = 0; i < NP; i++)
      drive_port(i, 1'b1, i[0], i[1], 1'b0, 32'h1000 + i, 32'h2000 + i);
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid != '0) bad++;
    end
    check("rst_no_resp", bad, 0);
    rst = 1'b0;

    // All ports continuously requesting, completion 1 cycle after m_cs.
    prev_t = 0;
    for (int k = 0; k < 8; k++) begin
      wait_ready(rv, t);
      check("rr_order", rv, NP'(1) << (k % NP));
      if (k > 0) check("rr_spacing", t - prev_t, 4);
      prev_t = t;
      respond(k % NP, 1, $urandom, MPU_NO_ERROR);
    end
    req_valid = '0;

    // Randomized traffic against the model.
    for (int n = 0; n < 30; n++) begin
      mask = NP'($urandom_range(1, 15));
      for (int i = 0; i < NP; i++)
        drive_port(i, mask[i], 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
      w = rr_pick(model_ptr, mask);
      wait_ready(rv, t);
      check("rand_grant", rv, NP'(1) << w);
      req_valid = '0;
      lat = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO - 1));
      e   = mpu_error_t'($urandom_range(0, 2));
      respond(w, lat, $urandom, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
